// File: rtl/branch_redirect_ctrl.sv
// Fetch-PC sequencer. It advances the PC by 4 on accepted fetches and redirects to the
// target after a fixed flush window when a branch is taken. Defining the optional macro
// BRANCH_MISALIGN_TRAP_EN sends misaligned taken targets to TRAP_VEC.
module branch_redirect_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
`ifdef BRANCH_MISALIGN_TRAP_EN
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100,
`endif
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_valid,
  input  logic            br_token,
  input  logic [XLEN-1:0] br_target,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            flush,
  output logic            busy,
  output logic [31:0]     redirect_cnt,
  output logic            misalign_trap
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [3:0]      fcnt, fcnt_n;
  logic [XLEN-1:0] target_q, target_n;
  logic [XLEN-1:0] pc_n;
  logic            pc_valid_n, flush_n, busy_n, trap_n;
  logic [31:0]     cnt_n;

  // Every output is held in a register; the comb block only computes next values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= BOOT;
      fcnt          <= '0;
      target_q      <= '0;
      pc            <= RESET_PC;
      pc_valid      <= 1'b0;
      flush         <= 1'b0;
      busy          <= 1'b1;
      redirect_cnt  <= '0;
      misalign_trap <= 1'b0;
    end else begin
      state         <= state_n;
      fcnt          <= fcnt_n;
      target_q      <= target_n;
      pc            <= pc_n;
      pc_valid      <= pc_valid_n;
      flush         <= flush_n;
      busy          <= busy_n;
      redirect_cnt  <= cnt_n;
      misalign_trap <= trap_n;
    end
  end

  always_comb begin
    state_n    = state;
    fcnt_n     = fcnt;
    target_n   = target_q;
    pc_n       = pc;
    pc_valid_n = pc_valid;
    flush_n    = flush;
    busy_n     = busy;
    cnt_n      = redirect_cnt;
    trap_n     = 1'b0;
    case (state)
      BOOT: begin
        state_n    = RUN;
        pc_valid_n = 1'b1;
        busy_n     = 1'b0;
        flush_n    = 1'b0;
      end
      RUN: begin
        // A taken branch wins over the sequential advance in the same cycle.
        if (br_valid && br_token) begin
`ifdef BRANCH_MISALIGN_TRAP_EN
          if (br_target[1:0] != 2'b00) begin
            target_n = TRAP_VEC;
            trap_n   = 1'b1;
          end else begin
            target_n = br_target;
          end
`else
          target_n = br_target & ~XLEN'(3);
`endif
          state_n    = FLUSH;
          fcnt_n     = 4'(FLUSH_CYCLES - 1);
          flush_n    = 1'b1;
          pc_valid_n = 1'b0;
          busy_n     = 1'b1;
          if (redirect_cnt != 32'hFFFF_FFFF) cnt_n = redirect_cnt + 32'd1;
        end else if (pc_valid && fetch_ready && !stall) begin
          pc_n = pc + XLEN'(4);
        end
      end
      FLUSH: begin
        if (fcnt == 4'd0) begin
          pc_n       = target_q;
          flush_n    = 1'b0;
          pc_valid_n = 1'b1;
          busy_n     = 1'b0;
          state_n    = RUN;
        end else begin
          fcnt_n = fcnt - 4'd1;
        end
      end
      default: begin
        state_n    = BOOT;
        pc_valid_n = 1'b0;
        flush_n    = 1'b0;
        busy_n     = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch sequencing rules.
module tb_branch_redirect_ctrl;

  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_token = 1'b0;
  logic [31:0] br_target = '0;
  logic        fetch_ready = 1'b0;
  logic [31:0] pc;
  logic        pc_valid, flush, busy, misalign_trap;
  logic [31:0] redirect_cnt;

  int checks = 0;
  int failures = 0;

  // Behavioural model: boot flag, remaining flush cycles, pending target.
  bit          mBoot;
  bit          mValid;
  bit          mTrap;
  int          mFlushLeft;
  logic [31:0] mPc, mTarget;
  longint      mCnt;

  branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_token(br_token),
    .br_target(br_target), .fetch_ready(fetch_ready), .pc(pc), .pc_valid(pc_valid),
    .flush(flush), .busy(busy), .redirect_cnt(redirect_cnt), .misalign_trap(misalign_trap)
  );

  always #5 clk = ~clk;

  task modelReset();
    mBoot = 1; mValid = 0; mTrap = 0; mFlushLeft = 0;
    mPc = 32'h0; mTarget = 32'h0; mCnt = 0;
  endtask

  task modelStep();
    mTrap = 0;
    if (mBoot) begin
      mBoot = 0;
      mValid = 1;
    end else if (mFlushLeft > 0) begin
      mFlushLeft--;
      if (mFlushLeft == 0) begin
        mPc = mTarget;
        mValid = 1;
      end
    end else if (br_valid && br_token) begin
`ifdef BRANCH_MISALIGN_TRAP_EN
      if (br_target % 4 != 0) begin
        mTarget = 32'h100;
        mTrap = 1;
      end else mTarget = br_target;
`else
      mTarget = br_target - (br_target % 4);
`endif
      mFlushLeft = FLUSH_CYCLES;
      mValid = 0;
      if (mCnt < 64'hFFFF_FFFF) mCnt++;
    end else if (fetch_ready && !stall) begin
      mPc = mPc + 32'd4;
    end
  endtask

  // Drives one cycle of inputs, lets the edge pass, then advances the model.
  task applyStimulus(input bit s, input bit bv, input bit bt, input logic [31:0] tg,
                     input bit fr);
    stall = s; br_valid = bv; br_token = bt; br_target = tg; fetch_ready = fr;
    @(posedge clk);
    #1;
    modelStep();
  endtask

  task test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    modelReset();
    checks++; if (pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=0", pc); end
    checks++; if (pc_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_pc_valid got=%b exp=0", pc_valid); end
    checks++; if (busy !== 1'b1 || flush !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_flush got=%b%b exp=10", busy, flush); end
    checks++; if (redirect_cnt !== 32'h0 || misalign_trap !== 1'b0) begin failures++; $display("[TB] FAIL reset_cnt_trap got=%h/%b exp=0/0", redirect_cnt, misalign_trap); end
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(0, 0, 0, 32'h0, 1);
    checks++; if (pc !== 32'h0 || pc_valid !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL boot_exit got=%h/%b/%b exp=0/1/0", pc, pc_valid, busy); end
  endtask

  task test_sequential();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 0, 0, 32'h0, 1);
      checks++; if (pc !== 32'(4 * i) || pc_valid !== 1'b1) begin failures++; $display("[TB] FAIL seq_pc step=%0d got=%h exp=%h", i, pc, 32'(4 * i)); end
    end
  endtask

  task test_stall();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 32'h0, 1);
      checks++; if (pc !== 32'h10) begin failures++; $display("[TB] FAIL stall_hold step=%0d got=%h exp=00000010", i, pc); end
    end
    applyStimulus(0, 0, 0, 32'h0, 1);
    checks++; if (pc !== 32'h14) begin failures++; $display("[TB] FAIL stall_release got=%h exp=00000014", pc); end
  endtask

  task test_taken_and_ignore();
    applyStimulus(1, 1, 1, 32'h200, 0);
    checks++; if (flush !== 1'b1 || pc_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL taken_n1 got=%b%b%b exp=101", flush, pc_valid, busy); end
    checks++; if (redirect_cnt !== 32'd1) begin failures++; $display("[TB] FAIL taken_cnt got=%0d exp=1", redirect_cnt); end
    applyStimulus(0, 1, 1, 32'h300, 1);
    checks++; if (flush !== 1'b1 || pc_valid !== 1'b0 || pc !== 32'h14) begin failures++; $display("[TB] FAIL taken_n2 got=%b%b pc=%h exp=10 pc=00000014", flush, pc_valid, pc); end
    applyStimulus(0, 1, 1, 32'h300, 0);
    checks++; if (pc !== 32'h200 || pc_valid !== 1'b1 || flush !== 1'b0) begin failures++; $display("[TB] FAIL taken_n3 got=%h/%b/%b exp=00000200/1/0", pc, pc_valid, flush); end
    checks++; if (redirect_cnt !== 32'd1) begin failures++; $display("[TB] FAIL ignore_cnt got=%0d exp=1", redirect_cnt); end
    applyStimulus(0, 1, 0, 32'h300, 1);
    checks++; if (pc !== 32'h204 || flush !== 1'b0) begin failures++; $display("[TB] FAIL not_taken got=%h exp=00000204", pc); end
  endtask

  task test_misalign();
    logic [31:0] expPc;
    bit expTrap;
`ifdef BRANCH_MISALIGN_TRAP_EN
    expPc = 32'h100; expTrap = 1;
`else
    expPc = 32'h200; expTrap = 0;
`endif
    applyStimulus(0, 1, 1, 32'h202, 1);
    checks++; if (misalign_trap !== expTrap) begin failures++; $display("[TB] FAIL misalign_trap got=%b exp=%b", misalign_trap, expTrap); end
    applyStimulus(0, 0, 0, 32'h0, 1);
    checks++; if (misalign_trap !== 1'b0) begin failures++; $display("[TB] FAIL trap_width got=%b exp=0", misalign_trap); end
    applyStimulus(0, 0, 0, 32'h0, 1);
    checks++; if (pc !== expPc || pc_valid !== 1'b1) begin failures++; $display("[TB] FAIL misalign_pc got=%h exp=%h", pc, expPc); end
    checks++; if (redirect_cnt !== 32'd2) begin failures++; $display("[TB] FAIL misalign_cnt got=%0d exp=2", redirect_cnt); end
  endtask

  task test_wrap();
    applyStimulus(0, 1, 1, 32'hFFFF_FFFC, 1);
    applyStimulus(0, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checks++; if (pc !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_pre got=%h exp=fffffffc", pc); end
    applyStimulus(0, 0, 0, 32'h0, 1);
    checks++; if (pc !== 32'h0 || pc_valid !== 1'b1) begin failures++; $display("[TB] FAIL wrap_pc got=%h exp=00000000", pc); end
  endtask

  task test_async_reset_midflush();
    applyStimulus(0, 1, 1, 32'h400, 1);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (pc !== 32'h0 || flush !== 1'b0 || busy !== 1'b1 || pc_valid !== 1'b0) begin failures++; $display("[TB] FAIL midflush_reset got=%h/%b/%b/%b exp=0/0/1/0", pc, flush, busy, pc_valid); end
    checks++; if (redirect_cnt !== 32'h0) begin failures++; $display("[TB] FAIL midflush_cnt got=%0d exp=0", redirect_cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
    applyStimulus(0, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checks++; if (pc !== 32'h8 || flush !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_pc got=%h exp=00000008", pc); end
  endtask

  task test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                    $urandom_range(0, 1) == 1, $urandom, ($urandom_range(0, 4) != 0));
      checks++; if (pc !== mPc) begin failures++; $display("[TB] FAIL rand_pc cyc=%0d got=%h exp=%h", i, pc, mPc); end
      checks++; if (pc_valid !== mValid) begin failures++; $display("[TB] FAIL rand_pc_valid cyc=%0d got=%b exp=%b", i, pc_valid, mValid); end
      checks++; if (flush !== (mFlushLeft > 0)) begin failures++; $display("[TB] FAIL rand_flush cyc=%0d got=%b exp=%b", i, flush, mFlushLeft > 0); end
      checks++; if (busy !== (mBoot || mFlushLeft > 0)) begin failures++; $display("[TB] FAIL rand_busy cyc=%0d got=%b", i, busy); end
      checks++; if (redirect_cnt !== 32'(mCnt)) begin failures++; $display("[TB] FAIL rand_cnt cyc=%0d got=%0d exp=%0d", i, redirect_cnt, mCnt); end
      checks++; if (misalign_trap !== mTrap) begin failures++; $display("[TB] FAIL rand_trap cyc=%0d got=%b exp=%b", i, misalign_trap, mTrap); end
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_sequential();
    test_stall();
    test_taken_and_ignore();
    test_misalign();
    test_wrap();
    test_async_reset_midflush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences the fetch PC from the resolved branch/jump outcome of the branch comparator (EX stage).
- Not taken: advances PC by 4 on each accepted fetch.
- Taken: captures the target, asserts a fixed-length flush window that kills younger in-flight instructions, then restarts fetch at the target.
- Sits between the branch comparator/EX stage and the instruction-fetch interface; sole owner of the architectural fetch PC.

Parameters:
XLEN, 32, datapath/PC width.
RESET_PC, 32'h0000_0000, fetch address after reset.
FLUSH_CYCLES, 2, flush window length in cycles; legal range 1..15.
TRAP_VEC, 32'h0000_0100, redirect address on misaligned target (used only with the optional feature).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
stall  in  1  back-end stall; freezes sequential PC advance.
br_valid  in  1  branch comparator result valid this cycle (resolved branch/JAL/JALR).
br_token  in  1  branch taken (always 1 for JAL/JALR).
br_target  in  XLEN  taken target address.
fetch_ready  in  1  fetch accepts pc this cycle.
pc  out  XLEN  current fetch address.
pc_valid  out  1  pc is a legal fetch request.
flush  out  1  kill all instructions younger than the redirecting branch.
busy  out  1  high whenever state != RUN.
redirect_cnt  out  32  count of taken redirects, saturating.
misalign_trap  out  1  one-cycle pulse on misaligned taken target.

Behaviour:
- All outputs are registered.
- Reset (async assert, sync release) → state BOOT, pc=RESET_PC, pc_valid=0, flush=0, busy=1, redirect_cnt=0, misalign_trap=0, flush counter=0.
- BOOT: unconditionally → RUN on the next edge. pc_valid=1 and busy=0 from that edge.
- RUN, fetch accepted (pc_valid & fetch_ready & !stall, no taken branch): pc <= pc+4, mod 2^XLEN; wraps from 32'hFFFF_FFFC to 0.
- RUN, taken branch (br_valid & br_token at cycle N; stall and fetch_ready ignored):
  - target_q <= br_target; state → FLUSH; counter <= FLUSH_CYCLES-1.
  - redirect_cnt += 1, saturating at 32'hFFFF_FFFF.
  - Taken branch has priority over the sequential advance in the same cycle; pc does not advance.
- br_valid & !br_token: no effect beyond the normal sequential rule.
- FLUSH:
  - flush=1, pc_valid=0, busy=1; pc holds its old value.
  - br_valid is ignored entirely; those instructions are being killed.
  - Counter decrements each cycle. At counter==0: pc <= target_q, flush <= 0, state → RUN, pc_valid <= 1.
- Timing: taken at N → flush high for cycles N+1..N+FLUSH_CYCLES; pc=target with pc_valid=1 at N+FLUSH_CYCLES+1.
- Target alignment: low 2 bits of br_target are forced to 0 before capture, unless the optional feature is enabled.
- rst asserted in any state, including mid-FLUSH, immediately returns all registers to reset values and discards target_q.
- Unused state encodings → BOOT.
- No combinational path from any input to any output.

Optional Feature:
- Macro: BRANCH_MISALIGN_TRAP_EN.
- Defined: a taken branch at cycle N with br_target[1:0] != 0 captures TRAP_VEC instead of the target.
  - misalign_trap=1 for exactly cycle N+1.
  - Flush sequence is identical to a normal taken branch.
  - redirect_cnt still increments.
- Undefined:
  - br_target[1:0] is forced to 2'b00.
  - misalign_trap is tied to 0.
  - TRAP_VEC is unused.

Test Plan:
- Reset release with fetch_ready=1, no branches → BOOT one cycle, then pc = 0, 4, 8, 12 on consecutive cycles with pc_valid=1; busy=0 from the RUN cycle.
- stall=1 for 3 cycles at pc=0x10 → pc holds 0x10; advances to 0x14 on the first unstalled accepted cycle.
- br_valid=1, br_token=1, br_target=0x200 at cycle N, FLUSH_CYCLES=2 → flush=1 at N+1 and N+2, pc_valid=0 there; pc=0x200 with pc_valid=1 at N+3; redirect_cnt=1.
- Second taken branch (target 0x300) during FLUSH → ignored; pc=0x200 after the window; redirect_cnt stays 1. A not-taken branch in RUN → sequential +4 only.
- br_target=0x202: without macro → pc=0x200, misalign_trap=0. With BRANCH_MISALIGN_TRAP_EN → misalign_trap pulse at N+1, pc=TRAP_VEC=0x100 at N+3.
- rst asserted asynchronously mid-FLUSH; pc=0xFFFF_FFFC sequential case → immediate reset values (pc=0, flush=0); wrap case yields pc=0 after one accepted fetch.
